// File: rtl/fb_writer_pkg.sv
// Shared types and defaults for the framebuffer stream writer: FSM state
// encoding, default geometry and the words-per-line helper.
package fb_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2,
        ST_DROP     = 2'd3
    } fb_state_t;

    localparam int DEFAULT_IMG_W  = 512;
    localparam int DEFAULT_IMG_H  = 256;
    localparam int WORDS_PER_LINE = DEFAULT_IMG_W / 2;
    localparam int ADDR_W         = 16;
    localparam int PIX_W          = 16;

    // Two 4:2:2 pixels share one 32-bit framebuffer word.
    function automatic int words_per_line(input int img_w);
        return img_w / 2;
    endfunction

endpackage

// File: rtl/fb_stream_writer_px_pair_pack.sv
// Pixel pair packer: holds the even pixel of a pair and emits a registered
// {odd, even} word with its valid flag when the odd pixel arrives.
module px_pair_pack
    import fb_writer_pkg::*;
(
    input  logic                 clk_150_d0,
    input  logic                 reset,
    input  logic                 ld_even,
    input  logic                 ld_odd,
    input  logic [PIX_W-1:0]     pix,
    output logic                 vld_p1,
    output logic [2*PIX_W-1:0]   pair_p1
);

    logic [PIX_W-1:0] even_p0;

    // Stage p0: even pixel waits here for its partner; an unpaired pixel is
    // simply overwritten by the next even pixel.
    always_ff @(posedge clk_150_d0) begin
        if (ld_even) begin
            even_p0 <= pix;
        end
    end

    // Stage p1: completed pair and its write strobe.
    always_ff @(posedge clk_150_d0) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            pair_p1 <= '0;
        end else begin
            vld_p1 <= ld_odd;
            if (ld_odd) begin
                pair_p1 <= {pix, even_p0};
            end
        end
    end

endmodule

// File: rtl/fb_stream_writer.sv
// AXI-Stream YCbCr 4:2:2 video to framebuffer writer: packs pixel pairs into
// 32-bit words, tracks frame position and counts framing errors.
module fb_stream_writer
    import fb_writer_pkg::*;
#(
    parameter int IMG_W = DEFAULT_IMG_W,
    parameter int IMG_H = DEFAULT_IMG_H
)
(
    input  logic               clk_150_d0,
    input  logic               reset,
    input  logic               enable,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [PIX_W-1:0]   s_tdata,
    input  logic               s_tuser,
    input  logic               s_tlast,
    output logic               wea,
    output logic [ADDR_W-1:0]  addra,
    output logic [31:0]        dina,
    output logic               frame_done,
    output logic [7:0]         err_cnt
);

    localparam int XW         = $clog2(IMG_W);
    localparam int YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LINE_WORDS = words_per_line(IMG_W);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_width
        $error("IMG_W must be even and at least 2");
    end
    if ((IMG_W * IMG_H) / 2 > 65536) begin : g_bad_size
        $error("IMG_W*IMG_H/2 exceeds the 16-bit framebuffer address space");
    end

    fb_state_t         state, state_nxt;
    logic [XW-1:0]     x, x_nxt;
    logic [YW-1:0]     y, y_nxt;
    logic              ld_even, ld_odd, err_inc, done_nxt;
    logic              acc, at_origin;
    logic [ADDR_W-1:0] word_addr;

    assign s_tready  = ~reset;
    assign acc       = s_tvalid & s_tready;
    assign at_origin = (x == '0) && (y == '0);
    assign word_addr = ADDR_W'(y) * ADDR_W'(LINE_WORDS) + ADDR_W'(x >> 1);

    always_ff @(posedge clk_150_d0) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        ld_even   = 1'b0;
        ld_odd    = 1'b0;
        err_inc   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF, ST_DROP: begin
                if (state == ST_DROP && !enable) begin
                    state_nxt = ST_IDLE;
                end else if (acc && s_tuser) begin
                    x_nxt = '0;
                    y_nxt = '0;
                    // SOF together with EOL is a one-pixel line.
                    if (s_tlast) begin
                        err_inc   = 1'b1;
                        state_nxt = ST_DROP;
                    end else begin
                        ld_even   = 1'b1;
                        x_nxt     = XW'(1);
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (acc) begin
                    if (s_tuser && !at_origin) begin
                        // Early SOF: restart the frame on this beat.
                        err_inc = 1'b1;
                        y_nxt   = '0;
                        if (s_tlast) begin
                            x_nxt     = '0;
                            state_nxt = ST_DROP;
                        end else begin
                            ld_even = 1'b1;
                            x_nxt   = XW'(1);
                        end
                    end else begin
                        ld_even = ~x[0];
                        ld_odd  = x[0];
                        if (x == X_LAST) begin
                            x_nxt = '0;
                            if (!s_tlast) begin
                                err_inc   = 1'b1;
                                y_nxt     = '0;
                                state_nxt = ST_DROP;
                            end else if (y == Y_LAST) begin
                                done_nxt  = 1'b1;
                                y_nxt     = '0;
                                state_nxt = enable ? ST_WAIT_SOF : ST_IDLE;
                            end else begin
                                y_nxt = y + YW'(1);
                            end
                        end else if (s_tlast) begin
                            // Short line: a completed pair still lands, a lone
                            // even pixel is dropped.
                            ld_even   = 1'b0;
                            err_inc   = 1'b1;
                            x_nxt     = '0;
                            y_nxt     = '0;
                            state_nxt = ST_DROP;
                        end else begin
                            x_nxt = x + XW'(1);
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_150_d0) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            addra      <= '0;
            frame_done <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            frame_done <= done_nxt;
            if (ld_odd) begin
                addra <= word_addr;
            end
            if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    px_pair_pack u_pack (
        .clk_150_d0 (clk_150_d0),
        .reset      (reset),
        .ld_even    (ld_even),
        .ld_odd     (ld_odd),
        .pix        (s_tdata),
        .vld_p1     (wea),
        .pair_p1    (dina)
    );

endmodule

// File: doc/fb_stream_writer.md
FB_STREAM_WRITER -- requirements
Module: fb_stream_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 512, meaning active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 256, meaning lines per frame.
REQ-003 SHALL have port clk_150_d0  in  1  pixel/write clock; reset reset, synchronous, active-high; clock clk_150_d0.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port enable  in  1  capture enable, sampled at frame boundaries.
REQ-006 SHALL have port s_tvalid  in  1  pixel beat valid.
REQ-007 SHALL have port s_tready  out  1  pixel beat ready.
REQ-008 SHALL have port s_tdata  in  16  YCbCr 4:2:2 pixel.
REQ-009 SHALL have port s_tuser  in  1  start of frame, on pixel (0,0).
REQ-010 SHALL have port s_tlast  in  1  end of line, on last pixel of a line.
REQ-011 SHALL have port wea  out  1  framebuffer write strobe.
REQ-012 SHALL have port addra  out  16  framebuffer word address.
REQ-013 SHALL have port dina  out  32  framebuffer write data.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse, full frame written.
REQ-015 SHALL have port err_cnt  out  8  saturating framing-error count.

Function
REQ-016 SHALL accept a beat when s_tvalid and s_tready are both high; s_tready SHALL be 1 in every state except during reset.
REQ-017 SHALL implement states IDLE, WAIT_SOF, RUN, DROP.
REQ-018 IDLE: discard beats; go to WAIT_SOF when enable=1.
REQ-019 WAIT_SOF: discard beats without s_tuser; an accepted beat with s_tuser=1 SHALL be pixel x=0, y=0 and move to RUN.
REQ-020 RUN: each accepted beat SHALL be stored at x, then increment x; the pixel at even x goes to dina[15:0], the pixel at x+1 goes to dina[31:16].
REQ-021 SHALL register wea=1, addra=y*(IMG_W/2)+x/2, and dina exactly 1 cycle after accepting an odd-x pixel; wea=0 on all other cycles.
REQ-022 A beat with s_tlast at x=IMG_W-1 SHALL clear x and increment y.
REQ-023 s_tlast at x<IMG_W-1 (short line) SHALL increment err_cnt, discard any unpaired pixel, and move to DROP.
REQ-024 x=IMG_W-1 without s_tlast (long line) SHALL write the final word normally, increment err_cnt, and move to DROP.
REQ-025 s_tuser in RUN at a position other than (0,0) SHALL increment err_cnt, discard any unpaired pixel, and restart the frame with that beat as pixel (0,0).
REQ-026 DROP: discard beats until a beat with s_tuser=1, which SHALL be handled as in REQ-019.
REQ-027 Completing line IMG_H-1 SHALL pulse frame_done in the same cycle as the last wea, clear x/y, and go to WAIT_SOF if enable=1, else IDLE.
REQ-028 Deasserting enable mid-frame SHALL NOT abort the frame; it takes effect at REQ-027 or on entry to DROP (DROP→IDLE).
REQ-029 s_tuser and s_tlast on the same beat SHALL count as a 1-pixel short line: err_cnt+1, no write, DROP.
REQ-030 err_cnt SHALL saturate at 255 and clear only on reset.
REQ-031 The x counter SHALL be ceil(log2(IMG_W)) bits and y SHALL be ceil(log2(IMG_H)) bits; addra SHALL be zero-extended to 16 bits; IMG_W*IMG_H/2 SHALL NOT exceed 65536 (elaboration check).

Reset
REQ-032 On reset: state=IDLE, x=y=0, s_tready=0, wea=0, addra=0, dina=0, frame_done=0, err_cnt=0.
REQ-033 Reset mid-frame SHALL abort with no further wea pulses; the partial pixel pair is lost.

Structure
REQ-034 Package fb_writer_pkg SHALL hold the state enum, default IMG_W/IMG_H, and WORDS_PER_LINE=IMG_W/2.
REQ-035 Sub-module px_pair_pack SHALL hold the even-pixel register and emit registered {odd,even} plus a valid signal; the FSM and counters stay in fb_stream_writer.

Verification
REQ-036 enable=1, one clean 512x256 frame with continuous valid → 65536 wea pulses, addra 0..65535 in order, frame_done once with addra=65535, err_cnt=0.
REQ-037 Pixels 0x1111,0x2222 at line 3 start → wea with addra=768, dina=0x22221111, one cycle after the 0x2222 beat.
REQ-038 Line 5 with s_tlast at x=100 → err_cnt=1, no writes until next s_tuser, next frame writes from addra 0.
REQ-039 Line 0 with 600 pixels and no s_tlast → last write addra=255, err_cnt=1, DROP until s_tuser.
REQ-040 s_tvalid toggling randomly 50% over a full frame → write contents identical to REQ-036.
REQ-041 Reset asserted mid line 10 → next cycle wea=0, err_cnt=0; beats ignored until enable and s_tuser.
